// File: rtl/text_cell_writer_if.sv
// rtl/text_cell_writer_if.sv - command stream, cell write port and status bundle for text_cell_writer
interface text_cell_writer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd;
   logic [12:0] arg;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        busy;

   // Command source side: issues commands, observes writes and status
   modport master (
      output cmd_valid, cmd, arg,
      input  cmd_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
   );

   // Writer side
   modport slave (
      input  cmd_valid, cmd, arg,
      output cmd_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
   );
endinterface

// File: rtl/text_cell_writer.sv
// rtl/text_cell_writer.sv - text cell array write front end with cursor, colors and clear fill (option: TEXT_WRITER_NEWLINE_EN)
module text_cell_writer #(
   parameter int          NUM_COLS   = 84,
   parameter int          NUM_ROWS   = 64,
   parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
   input  logic               i_clk,
   input  logic               i_rst,
   text_cell_writer_if.slave  bus
);

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   localparam logic [1:0] OP_PUT_CHAR   = 2'd0;
   localparam logic [1:0] OP_SET_CURSOR = 2'd1;
   localparam logic [1:0] OP_SET_COLOR  = 2'd2;
   localparam logic [1:0] OP_CLEAR      = 2'd3;

   localparam logic [6:0] LAST_COL = 7'(NUM_COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(NUM_ROWS - 1);

   state_t      state,     nxt_state;
   logic [6:0]  cur_col,   nxt_cur_col;
   logic [5:0]  cur_row,   nxt_cur_row;
   logic [3:0]  fg,        nxt_fg;
   logic [3:0]  bg,        nxt_bg;
   logic        wr_en,     nxt_wr_en;
   logic [12:0] wr_addr,   nxt_wr_addr;
   logic [15:0] wr_data,   nxt_wr_data;
   logic        busy,      nxt_busy;

   logic        cmd_accept;
   logic [7:0]  put_char;
   logic        is_newline;
   logic        is_return;
   logic [6:0]  col_inc;
   logic [5:0]  row_inc;
   logic [6:0]  set_col;
   logic [6:0]  clr_col;
   logic [5:0]  clr_row;

   assign bus.cmd_ready  = !i_rst && (state == S_IDLE);
   assign cmd_accept     = bus.cmd_valid && bus.cmd_ready;

   assign put_char = bus.arg[7:0];

`ifdef TEXT_WRITER_NEWLINE_EN
   assign is_newline = (put_char == 8'h0A);
   assign is_return  = (put_char == 8'h0D);
`else
   assign is_newline = 1'b0;
   assign is_return  = 1'b0;
`endif

   // Wrapped neighbours of the cursor; row wraps independently of column
   assign col_inc = (cur_col == LAST_COL) ? 7'd0 : cur_col + 7'd1;
   assign row_inc = (cur_row == LAST_ROW) ? 6'd0 : cur_row + 6'd1;

   // Out-of-range SET_CURSOR columns pin to the rightmost column
   assign set_col = (bus.arg[12:6] > LAST_COL) ? LAST_COL : bus.arg[12:6];

   // The fill walks the address register itself: column-major, rows fastest
   assign clr_col = wr_addr[12:6];
   assign clr_row = wr_addr[5:0];

   // Next-state and output decode for command handling and the clear fill
   always_comb begin
      nxt_state   = state;
      nxt_cur_col = cur_col;
      nxt_cur_row = cur_row;
      nxt_fg      = fg;
      nxt_bg      = bg;
      nxt_wr_en   = 1'b0;
      nxt_wr_addr = wr_addr;
      nxt_wr_data = wr_data;
      nxt_busy    = busy;

      case (state)
         S_IDLE: begin
            if (cmd_accept) begin
               case (bus.cmd)
                  OP_PUT_CHAR: begin
                     if (is_newline) begin
                        nxt_cur_col = 7'd0;
                        nxt_cur_row = row_inc;
                     end else if (is_return) begin
                        nxt_cur_col = 7'd0;
                     end else begin
                        nxt_wr_en   = 1'b1;
                        nxt_wr_addr = {cur_col, cur_row};
                        nxt_wr_data = {fg, bg, put_char};
                        nxt_cur_col = col_inc;
                        if (cur_col == LAST_COL) begin
                           nxt_cur_row = row_inc;
                        end
                     end
                  end
                  OP_SET_CURSOR: begin
                     nxt_cur_col = set_col;
                     nxt_cur_row = bus.arg[5:0];
                  end
                  OP_SET_COLOR: begin
                     nxt_fg = bus.arg[7:4];
                     nxt_bg = bus.arg[3:0];
                  end
                  OP_CLEAR: begin
                     nxt_state   = S_CLEAR;
                     nxt_busy    = 1'b1;
                     nxt_wr_en   = 1'b1;
                     nxt_wr_addr = 13'd0;
                     nxt_wr_data = {fg, bg, CLEAR_CHAR};
                  end
                  default: begin
                  end
               endcase
            end
         end
         S_CLEAR: begin
            if ((clr_col == LAST_COL) && (clr_row == LAST_ROW)) begin
               nxt_state   = S_IDLE;
               nxt_busy    = 1'b0;
               nxt_cur_col = 7'd0;
               nxt_cur_row = 6'd0;
            end else begin
               nxt_wr_en = 1'b1;
               if (clr_row == LAST_ROW) begin
                  nxt_wr_addr = {clr_col + 7'd1, 6'd0};
               end else begin
                  nxt_wr_addr = {clr_col, clr_row + 6'd1};
               end
            end
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any fill in progress
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         cur_col <= 7'd0;
         cur_row <= 6'd0;
         fg      <= 4'hF;
         bg      <= 4'h0;
         wr_en   <= 1'b0;
         wr_addr <= 13'd0;
         wr_data <= 16'd0;
         busy    <= 1'b0;
      end else begin
         state   <= nxt_state;
         cur_col <= nxt_cur_col;
         cur_row <= nxt_cur_row;
         fg      <= nxt_fg;
         bg      <= nxt_bg;
         wr_en   <= nxt_wr_en;
         wr_addr <= nxt_wr_addr;
         wr_data <= nxt_wr_data;
         busy    <= nxt_busy;
      end
   end

   assign bus.wr_en      = wr_en;
   assign bus.wr_addr    = wr_addr;
   assign bus.wr_data    = wr_data;
   assign bus.cursor_col = cur_col;
   assign bus.cursor_row = cur_row;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_text_cell_writer.sv
// tb/tb_text_cell_writer.sv - scoreboard bench for text_cell_writer with a cursor-index reference model
module tb_text_cell_writer;

   localparam int NC     = 84;
   localparam int NR     = 64;
   localparam int NCELLS = NC * NR;

`ifdef TEXT_WRITER_NEWLINE_EN
   localparam bit NL_MODE = 1'b1;
`else
   localparam bit NL_MODE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   text_cell_writer_if bus();

   text_cell_writer #(
      .NUM_COLS   (NC),
      .NUM_ROWS   (NR),
      .CLEAR_CHAR (8'h20)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   // Reference model state: cursor, colors, and how many fill writes to expect
   int m_col, m_row, m_fg, m_bg;
   int n_clear = NCELLS;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
      end
   endtask

   task automatic model_reset();
      m_col = 0;
      m_row = 0;
      m_fg  = 15;
      m_bg  = 0;
   endtask

   // Apply one accepted command to the model; acc is the cycle index at acceptance
   task automatic model_cmd(input int op, input int a, input int acc);
      int ch, pos, c;
      case (op)
         0: begin
            ch = a & 255;
            if (NL_MODE && ch == 10) begin
               m_col = 0;
               m_row = (m_row + 1) % NR;
            end else if (NL_MODE && ch == 13) begin
               m_col = 0;
            end else begin
               sb.push_back('{addr: m_col * NR + m_row,
                              data: (m_fg << 12) | (m_bg << 8) | ch,
                              cyc:  acc + 1});
               pos   = (m_row * NC + m_col + 1) % NCELLS;
               m_col = pos % NC;
               m_row = pos / NC;
            end
         end
         1: begin
            c     = (a >> 6) & 127;
            m_col = (c > NC - 1) ? NC - 1 : c;
            m_row = a & 63;
         end
         2: begin
            m_fg = (a >> 4) & 15;
            m_bg = a & 15;
         end
         default: begin
            for (int k = 0; k < n_clear; k++)
               sb.push_back('{addr: k, data: (m_fg << 12) | (m_bg << 8) | 32, cyc: acc + 1 + k});
            m_col = 0;
            m_row = 0;
         end
      endcase
   endtask

   // Called at a negedge; returns at the negedge after acceptance with valid dropped
   task automatic send(input int op, input int a, output int acc);
      int guard;
      guard = 0;
      acc = -1;
      bus.cmd_valid = 1'b1;
      bus.cmd       = 2'(op);
      bus.arg       = 13'(a);
      while (!bus.cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.cmd_ready) begin
         check("cmd_ready_timeout", 0, 1);
         bus.cmd_valid = 1'b0;
      end else begin
         acc = cyc;
         model_cmd(op, a, acc);
         @(posedge clk);
         @(negedge clk);
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic send_chk(input int op, input int a);
      int acc;
      send(op, a, acc);
      check("cursor_col", int'(bus.cursor_col), m_col);
      check("cursor_row", int'(bus.cursor_row), m_row);
   endtask

   // Monitor: every write strobe must match the head of the scoreboard, on time
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.wr_en) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr %0d data 0x%04h at cycle %0d, none expected", bus.wr_addr, bus.wr_data, cyc);
         end else begin
            e = sb.pop_front();
            if (int'(bus.wr_addr) != e.addr || int'(bus.wr_data) != e.data || cyc != e.cyc) begin
               fails++;
               $display("FAIL write: got addr %0d data 0x%04h cycle %0d expected addr %0d data 0x%04h cycle %0d",
                        bus.wr_addr, bus.wr_data, cyc, e.addr, e.data, e.cyc);
            end
         end
      end
      if (bus.busy) check("ready_during_clear", int'(bus.cmd_ready), 0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, guard, op, a, ch;
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'd0;
      bus.arg       = 13'd0;
      model_reset();

      repeat (3) @(negedge clk);
      check("rst_wr_en",   int'(bus.wr_en), 0);
      check("rst_wr_addr", int'(bus.wr_addr), 0);
      check("rst_wr_data", int'(bus.wr_data), 0);
      check("rst_cursor",  int'({bus.cursor_col, bus.cursor_row}), 0);
      check("rst_busy",    int'(bus.busy), 0);
      check("rst_ready",   int'(bus.cmd_ready), 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset colors F/0 reach the cell data
      send_chk(0, 'h33);
      check("reset_colors_data", int'(bus.wr_data), 'hF033);

      // Color then character at origin
      send_chk(1, 0);
      send_chk(2, 'h1E);
      send_chk(0, 'h41);
      check("first_put_data", int'(bus.wr_data), 'h1E41);
      check("first_put_addr", int'(bus.wr_addr), 0);
      check("first_put_cursor", int'({bus.cursor_col, bus.cursor_row}), (1 << 6) | 0);

      // Last cell then wrap to origin, back to back
      send_chk(1, (83 << 6) | 63);
      send_chk(0, 'h5A);
      check("last_cell_addr", int'(bus.wr_addr), 5375);
      send_chk(0, 'h5A);
      check("wrap_addr", int'(bus.wr_addr), 0);
      check("wrap_cursor", int'({bus.cursor_col, bus.cursor_row}), (1 << 6) | 0);

      // Column clamp, no write
      send_chk(1, (100 << 6) | 5);
      check("clamp_cursor", int'({bus.cursor_col, bus.cursor_row}), (83 << 6) | 5);

      // Line feed handling depends on build option
      send_chk(1, (10 << 6) | 4);
      send_chk(0, 'h0A);
`ifdef TEXT_WRITER_NEWLINE_EN
      check("lf_cursor", int'({bus.cursor_col, bus.cursor_row}), (0 << 6) | 5);
`else
      check("lf_addr", int'(bus.wr_addr), (10 << 6) | 4);
      check("lf_cursor", int'({bus.cursor_col, bus.cursor_row}), (11 << 6) | 4);
`endif

      // Randomized command mix
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         a  = int'($urandom & 32'h1FFF);
         if (op <= 5) begin
            ch = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 'h0A : 'h0D) : (a & 255);
            send_chk(0, (a & 'h1F00) | ch);
         end else if (op <= 7) begin
            send_chk(1, a);
         end else begin
            send_chk(2, a);
         end
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Full clear with colors 7/0
      send_chk(2, 'h70);
      n_clear = NCELLS;
      send(3, 0, acc);
      check("clear_busy_start", int'(bus.busy), 1);
      guard = 0;
      while (bus.busy && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      check("clear_done_cycle", cyc, acc + 5377);
      check("clear_ready_after", int'(bus.cmd_ready), 1);
      check("clear_cursor", int'({bus.cursor_col, bus.cursor_row}), 0);
      check("clear_all_written", sb.size(), 0);

      // Reset while the fill is at address 100
      send_chk(2, 'h5C);
      send_chk(1, (20 << 6) | 7);
      n_clear = 101;
      send(3, 0, acc);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_wr_en", int'(bus.wr_en), 0);
      check("abort_busy", int'(bus.busy), 0);
      rst = 1'b0;
      model_reset();
      check("abort_cursor", int'({bus.cursor_col, bus.cursor_row}), 0);
      repeat (20) @(negedge clk);
      send_chk(0, 'h21);
      check("abort_colors_data", int'(bus.wr_data), 'hF021);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
